// File: rtl/operand_gather.sv
// operand_gather: packs WIDTH-bit words into 4-operand groups; issue 1 cycle after the 4th word, prod_valid LAT cycles after op_valid.
// Backpressure: in_ready drops only while a full group waits for credit. OPERAND_GATHER_LAST_PAD_EN enables in_last padding with 1s.
module operand_gather #(
   parameter int WIDTH   = 15,
   parameter int LAT     = 2,
   parameter int CREDITS = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   output logic [WIDTH-1:0] data_in1,
   output logic [WIDTH-1:0] data_in2,
   output logic [WIDTH-1:0] data_in3,
   output logic [WIDTH-1:0] data_in4,
   output logic             op_valid,
   output logic             prod_valid,
   input  logic             credit_ret,
   output logic             credit_err
);

   localparam int CW = $clog2(CREDITS + 1);

   typedef enum logic {COLLECT, FULL} state_t;

   state_t           state;
   logic [2:0]       cnt;
   logic [2:0]       cnt_nxt;
   logic [2:0]       cnt_base;
   logic [1:0]       widx;
   logic [WIDTH-1:0] slot     [4];
   logic [WIDTH-1:0] slot_nxt [4];
   logic [CW-1:0]    cred;
   logic [LAT-1:0]   lat_sr;
   logic             issue;
   logic             accept;

   assign issue    = (state == FULL) && (cred != '0);
   assign in_ready = (state == COLLECT) || issue;
   assign accept   = in_valid && in_ready;

`ifndef OPERAND_GATHER_LAST_PAD_EN
   logic in_last_unused;
   assign in_last_unused = in_last;
`endif

   // A word taken on an issue edge starts the next group in slot 0.
   always_comb begin
      slot_nxt = slot;
      cnt_base = issue ? 3'd0 : cnt;
      widx     = issue ? 2'd0 : cnt[1:0];
      cnt_nxt  = cnt_base;
      if (accept) begin
         slot_nxt[widx] = in_data;
         cnt_nxt        = cnt_base + 3'd1;
`ifdef OPERAND_GATHER_LAST_PAD_EN
         if (in_last) begin
            for (int i = 0; i < 4; i++) begin
               if (3'(i) >= cnt_nxt) slot_nxt[i] = {{(WIDTH-1){1'b0}}, 1'b1};
            end
            cnt_nxt = 3'd4;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= COLLECT;
         cnt        <= 3'd0;
         slot       <= '{default: '0};
         cred       <= CW'(CREDITS);
         credit_err <= 1'b0;
         op_valid   <= 1'b0;
         lat_sr     <= '0;
         data_in1   <= '0;
         data_in2   <= '0;
         data_in3   <= '0;
         data_in4   <= '0;
      end else begin
         cnt      <= cnt_nxt;
         state    <= (cnt_nxt == 3'd4) ? FULL : COLLECT;
         slot     <= slot_nxt;
         op_valid <= issue;
         lat_sr   <= (lat_sr << 1) | LAT'(op_valid);
         if (issue) begin
            data_in1 <= slot[0];
            data_in2 <= slot[1];
            data_in3 <= slot[2];
            data_in4 <= slot[3];
         end
         if (credit_ret && !issue) begin
            if (cred < CW'(CREDITS)) cred <= cred + CW'(1);
            else                     credit_err <= 1'b1;
         end else if (issue && !credit_ret) begin
            cred <= cred - CW'(1);
         end
      end
   end

   assign prod_valid = lat_sr[LAT-1];

endmodule

// File: doc/operand_gather.md
# operand_gather

Upstream feeder for the four-operand 15-bit product pipeline. Accepts a serial stream of 15-bit operand words over a valid/ready handshake, packs them into groups of four and presents each group on four registered operand buses. It also tracks the fixed two-stage product latency, so a `prod_valid` strobe lines up exactly with the 60-bit product register. Issue is throttled by a credit counter so the product consumer is never overrun; the product pipeline itself has no stall.

## Interface
- `WIDTH`, 15, operand word width; must match product pipeline operand width.
- `LAT`, 2, register stages between operand update and product register update.
- `CREDITS`, 4, product slots available downstream after reset; range 1..15.

- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset, sampled on `clk` rising edge.
- `in_data` input WIDTH: operand word.
- `in_valid` input 1: `in_data` valid.
- `in_last` input 1: marks the final word of a partial group; only meaningful with the macro enabled.
- `in_ready` output 1: word accepted when `in_valid && in_ready` at a rising edge.
- `data_in1`..`data_in4` output WIDTH each: registered operand group; slot 0 maps to `data_in1`.
- `op_valid` output 1: one-cycle pulse, high the cycle after a group issues.
- `prod_valid` output 1: `op_valid` delayed `LAT` cycles; qualifies the product register.
- `credit_ret` input 1: one pulse per product consumed downstream.
- `credit_err` output 1: sticky flag, set on a credit return while the counter is already full.

## Operation
- Collector: four WIDTH-bit slot registers plus slot count `cnt` (0..4).
  - Accepted words are written to slot `cnt`; `cnt` then increments.
- Credit counter `cred`: width $clog2(CREDITS+1); reset value CREDITS.
- States:
  - COLLECT when `cnt` < 4.
  - FULL when `cnt` == 4.
- `issue` = FULL && `cred` > 0. On an issue edge:
  - `data_in1..4` take slots 0..3.
  - `op_valid` goes high for the next cycle.
  - `cred` decrements.
- `in_ready` = (`cnt` < 4) || `issue`.
  - A word accepted on an issue edge goes into slot 0 and `cnt` becomes 1.
  - Otherwise `cnt` becomes 0.
  - Result: zero-bubble streaming at one word per cycle while credits last.
- FULL with `cred` == 0: `in_ready` = 0. The group and operand buses hold until a credit arrives.
- Credit update when `issue` and `credit_ret` occur together: `cred` is unchanged.
- Credit update on `credit_ret` without `issue`:
  - If `cred` < CREDITS, `cred` increments.
  - Otherwise `cred` saturates and `credit_err` is set; it clears only on reset.
- Operand buses change only on issue edges, so the product register is stable between strobes.
- No arithmetic is performed in this block; the full WIDTH is passed through unmodified.

## Timing
- Reset (`rst_n` low at an edge):
  - `data_in1..4` = 0, `op_valid` = 0, `prod_valid` = 0, `credit_err` = 0.
  - `cnt` = 0, `cred` = CREDITS, LAT delay chain cleared.
  - `in_ready` = 1 on the first cycle after reset.
- Reset asserted mid-group or mid-flight: the partial group is discarded and in-flight `prod_valid` pulses are dropped.
- Latency from the 4th accepted word (edge E):
  - If credit is present and the group was previously in COLLECT, the issue happens at edge E+1.
  - `op_valid` is high during cycle E+1..E+2.
  - `prod_valid` is high LAT cycles later, during E+3..E+4 for LAT = 2. This coincides with the product register holding that group's product.
- Back-to-back groups: one `op_valid` per 4 accepted words.
  - Sustained throughput is one group per 4 cycles.
  - Limited by CREDITS over the round-trip time of `credit_ret`.
- `prod_valid` is a pure shift of `op_valid` and is never suppressed by credit state.

## Configuration
- `OPERAND_GATHER_LAST_PAD_EN` defined:
  - An accepted word with `in_last` = 1 while `cnt` becomes 1..3 pads the remaining slots with the value 1 (the multiplicative identity) and forces FULL.
  - The product then equals the product of the supplied words.
  - `in_last` on the 4th word has no extra effect.
- Macro undefined:
  - `in_last` is ignored and groups always require 4 words.
  - The padding logic is not compiled in.

## Test plan
- Reset, then stream words 3,5,7,11 on consecutive cycles -> one `op_valid`; `data_in1..4` = 3,5,7,11; `prod_valid` LAT cycles after `op_valid`; product register = 1155.
- 16 continuous words with `credit_ret` tied high one cycle after each `prod_valid` -> 4 `op_valid` pulses; `in_ready` never drops; operands match each consecutive quadruple.
- CREDITS = 4, no credit return, 20 words offered -> exactly 4 issues; `in_ready` low with `cnt` = 4; one `credit_ret` pulse -> 5th group issues on the next edge.
- Macro on: words 2,9 with `in_last` on the 9 -> `data_in1..4` = 2,9,1,1; product 18. Macro off: same stimulus -> no issue until two more words arrive.
- Reset pulsed with 2 words collected and one `prod_valid` pending -> no `op_valid`/`prod_valid` afterward; next 4 words form a fresh group; `cred` = CREDITS.
- `credit_ret` pulsed with `cred` = CREDITS -> `credit_err` = 1 and stays 1; with `issue` and `credit_ret` in the same cycle -> `cred` unchanged.
